func_sweep_ctrl: RTL and testbench

//  Synthesizable sweep sequencer for a function-emulator datapath: drives the DUT fixed-point input

---
 rtl/func_sweep_ctrl.sv | 249 ++++++++++++++++++++++++
 tb/tb_func_sweep_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/func_sweep_ctrl.sv
// Sweep sequencer: steps a function block's input from cfg_start to cfg_stop and streams (in, out) samples.
// Latency: start pulse to first samp_valid is SETTLE_CYC+2 cycles; each later point takes SETTLE_CYC+2 cycles
// (STEP + SETTLE + EMIT) plus any consumer stall. Backpressure: samp_valid holds in EMIT until samp_ready; no drop.
//
// Ports:
//   emu_clk, emu_rst_n        clock, asynchronous active-low reset
//   start, abort              1-cycle sweep start pulse; level abort (wins over start)
//   cfg_start/step/stop       signed sweep configuration, captured when a start is accepted
//   in_ / out                 drive to / response from the function block
//   busy, done                sweep in progress / sweep finished (held until next start)
//   samp_valid/ready/in/out/idx  sample stream, valid/ready handshake
//   n_samp                    samples accepted in current/last sweep (saturating)
//   out_min, out_max          only with SWEEP_STATS_EN: extremes of accepted samp_out
//
// Optional feature macro: SWEEP_STATS_EN (adds out_min/out_max tracking).

module func_sweep_ctrl #(
  parameter int IN_W       = 16,
  parameter int OUT_W      = 16,
  parameter int SETTLE_CYC = 8,
  parameter int IDX_W      = 16
) (
  input  logic             emu_clk,
  input  logic             emu_rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [IN_W-1:0]  cfg_start,
  input  logic [IN_W-1:0]  cfg_step,
  input  logic [IN_W-1:0]  cfg_stop,
  output logic [IN_W-1:0]  in_,
  input  logic [OUT_W-1:0] out,
  output logic             busy,
  output logic             done,
  output logic             samp_valid,
  input  logic             samp_ready,
  output logic [IN_W-1:0]  samp_in,
  output logic [OUT_W-1:0] samp_out,
  output logic [IDX_W-1:0] samp_idx,
  output logic [IDX_W-1:0] n_samp
`ifdef SWEEP_STATS_EN
  ,
  output logic [OUT_W-1:0] out_min,
  output logic [OUT_W-1:0] out_max
`endif
);

  // Settle counter only needs to reach SETTLE_CYC-1.
  localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_EMIT   = 3'd3,
    ST_STEP   = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  state_t state_q, state_d;

  logic [IN_W-1:0]  cfg_start_q;
  logic [IN_W-1:0]  cfg_step_q;
  logic [IN_W-1:0]  cfg_stop_q;
  logic [IN_W-1:0]  in_q;
  logic [IN_W-1:0]  samp_in_q;
  logic [OUT_W-1:0] samp_out_q;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] n_samp_q;
  logic [CNT_W-1:0] cnt_q;

  logic start_acc;   // start accepted from IDLE/DONE
  logic settle_end;  // last settle cycle of the current point
  logic handshake;   // sample transferred this cycle
  logic in_range;    // next point is to be visited

  // ---------------------------------------------------------------------------
  // Next-point arithmetic. The sum is formed one bit wider so that a wrap past
  // the IN_W range is visible as a mismatch of the two top bits; the stop
  // comparison is also done at the wider width so an overflowed value can
  // never look "in range".
  // ---------------------------------------------------------------------------
  logic [IN_W:0]        next_w;
  logic signed [IN_W:0] next_s;
  logic signed [IN_W:0] stop_s;
  logic                 no_ovf;
  logic                 step_pos;
  logic                 step_neg;

  always_comb begin
    next_w   = {in_q[IN_W-1], in_q} + {cfg_step_q[IN_W-1], cfg_step_q};
    next_s   = $signed(next_w);
    stop_s   = $signed({cfg_stop_q[IN_W-1], cfg_stop_q});
    no_ovf   = (next_w[IN_W] == next_w[IN_W-1]);
    step_neg = cfg_step_q[IN_W-1];
    step_pos = !cfg_step_q[IN_W-1] && (|cfg_step_q);
    // A zero step matches neither direction, so such a sweep ends after one sample.
    in_range = no_ovf && ((step_pos && (next_s <= stop_s)) ||
                          (step_neg && (next_s >= stop_s)));
  end

  assign start_acc  = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && start && !abort;
  assign settle_end = (state_q == ST_SETTLE) && (cnt_q == CNT_LAST);
  // A sample the consumer takes in the same cycle as abort has left the block,
  // so it is counted; only a sample still waiting is discarded.
  assign handshake  = (state_q == ST_EMIT) && samp_ready;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge emu_clk or negedge emu_rst_n) begin
    if (!emu_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic. Abort dominates every busy state and also
  // suppresses a start in IDLE/DONE.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_acc) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        state_d = abort ? ST_DONE : ST_SETTLE;
      end
      ST_SETTLE: begin
        if (abort)           state_d = ST_DONE;
        else if (settle_end) state_d = ST_EMIT;
      end
      ST_EMIT: begin
        if (abort)           state_d = ST_DONE;
        else if (samp_ready) state_d = ST_STEP;
      end
      ST_STEP: begin
        if (abort || !in_range) state_d = ST_DONE;
        else                    state_d = ST_SETTLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs decoded from the registered state
  // ---------------------------------------------------------------------------
  always_comb begin
    busy       = 1'b0;
    done       = 1'b0;
    samp_valid = 1'b0;
    unique case (state_q)
      ST_LOAD, ST_SETTLE, ST_STEP: busy = 1'b1;
      ST_EMIT: begin
        busy       = 1'b1;
        samp_valid = 1'b1;
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge emu_clk or negedge emu_rst_n) begin
    if (!emu_rst_n) begin
      cfg_start_q <= '0;
      cfg_step_q  <= '0;
      cfg_stop_q  <= '0;
      in_q        <= '0;
      samp_in_q   <= '0;
      samp_out_q  <= '0;
      idx_q       <= '0;
      n_samp_q    <= '0;
      cnt_q       <= '0;
    end else begin
      if (start_acc) begin
        cfg_start_q <= cfg_start;
        cfg_step_q  <= cfg_step;
        cfg_stop_q  <= cfg_stop;
      end

      if ((state_q == ST_LOAD) && !abort) begin
        in_q     <= cfg_start_q;
        idx_q    <= '0;
        n_samp_q <= '0;
        cnt_q    <= '0;
      end

      if ((state_q == ST_SETTLE) && !abort) begin
        if (settle_end) begin
          // in_ has been stable for SETTLE_CYC cycles: the pair is coherent.
          samp_in_q  <= in_q;
          samp_out_q <= out;
          cnt_q      <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end

      if (handshake && (n_samp_q != {IDX_W{1'b1}})) begin
        n_samp_q <= n_samp_q + 1'b1;
      end

      if ((state_q == ST_STEP) && !abort && in_range) begin
        in_q  <= next_w[IN_W-1:0];
        idx_q <= idx_q + 1'b1;   // wraps by design
        cnt_q <= '0;
      end
    end
  end

  assign in_      = in_q;
  assign samp_in  = samp_in_q;
  assign samp_out = samp_out_q;
  assign samp_idx = idx_q;
  assign n_samp   = n_samp_q;

`ifdef SWEEP_STATS_EN
  // Extremes start at the opposite ends (+max / -max) so the first accepted
  // sample overwrites both.
  localparam logic [OUT_W-1:0] OUT_POS_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] OUT_NEG_MAX = {1'b1, {(OUT_W-2){1'b0}}, 1'b1};

  logic [OUT_W-1:0] out_min_q;
  logic [OUT_W-1:0] out_max_q;

  always_ff @(posedge emu_clk or negedge emu_rst_n) begin
    if (!emu_rst_n) begin
      out_min_q <= OUT_POS_MAX;
      out_max_q <= OUT_NEG_MAX;
    end else if ((state_q == ST_LOAD) && !abort) begin
      out_min_q <= OUT_POS_MAX;
      out_max_q <= OUT_NEG_MAX;
    end else if (handshake) begin
      if ($signed(samp_out_q) < $signed(out_min_q)) out_min_q <= samp_out_q;
      if ($signed(samp_out_q) > $signed(out_max_q)) out_max_q <= samp_out_q;
    end
  end

  assign out_min = out_min_q;
  assign out_max = out_max_q;
`endif

endmodule

// File: tb/tb_func_sweep_ctrl.sv
module tb_func_sweep_ctrl;

  localparam int SET = 8;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [15:0] cfg_start;
  logic [15:0] cfg_step;
  logic [15:0] cfg_stop;
  logic [15:0] in_w;
  logic [15:0] dut_out;
  logic        busy;
  logic        done;
  logic        samp_valid;
  logic        samp_ready;
  logic [15:0] samp_in;
  logic [15:0] samp_out;
  logic [15:0] samp_idx;
  logic [15:0] n_samp;
`ifdef SWEEP_STATS_EN
  logic [15:0] out_min;
  logic [15:0] out_max;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  func_sweep_ctrl #(
    .IN_W(16), .OUT_W(16), .SETTLE_CYC(SET), .IDX_W(16)
  ) dut (
    .emu_clk    (clk),
    .emu_rst_n  (rst_n),
    .start      (start),
    .abort      (abort),
    .cfg_start  (cfg_start),
    .cfg_step   (cfg_step),
    .cfg_stop   (cfg_stop),
    .in_        (in_w),
    .out        (dut_out),
    .busy       (busy),
    .done       (done),
    .samp_valid (samp_valid),
    .samp_ready (samp_ready),
    .samp_in    (samp_in),
    .samp_out   (samp_out),
    .samp_idx   (samp_idx),
    .n_samp     (n_samp)
`ifdef SWEEP_STATS_EN
    ,
    .out_min    (out_min),
    .out_max    (out_max)
`endif
  );

  // Function block stand-in: out = 2 * in (16-bit wrap).
  assign dut_out = 16'(int'($signed(in_w)) * 2);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] exp_in(input logic [15:0] s, input logic [15:0] st, input int k);
    return 16'(int'($signed(s)) + k * int'($signed(st)));
  endfunction

  function automatic logic [15:0] exp_out(input logic [15:0] x);
    return 16'(int'($signed(x)) * 2);
  endfunction

  // Runs one sweep with ready high except for 5 stall cycles at sample stall_at,
  // during which a (to-be-ignored) start with a different cfg is also pulsed.
  task automatic run_sweep(input logic [15:0] s, input logic [15:0] st, input logic [15:0] sp,
                           input int exp_n, input logic [15:0] exp_last, input int stall_at);
    int  k     = 0;
    int  cyc   = 0;
    int  stall = 0;
    bit  first = 1'b1;
    logic [15:0] e;
    @(negedge clk);
    cfg_start = s; cfg_step = st; cfg_stop = sp;
    start = 1'b1; samp_ready = 1'b1;
    @(negedge clk);
    start = 1'b0; cyc = 1;
    while (!done && cyc < 400) begin
      if (samp_valid) begin
        if (first) chk("first_valid_latency", 32'(cyc), 32'(SET + 2));
        first = 1'b0;
        e = exp_in(s, st, k);
        chk("samp_in", 32'(samp_in), 32'(e));
        chk("samp_out", 32'(samp_out), 32'(exp_out(e)));
        chk("samp_idx", 32'(samp_idx), 32'(k));
        if (k == stall_at && stall < 5) begin
          samp_ready = 1'b0;
          start      = 1'b1;
          cfg_start  = 16'h1234;
          stall++;
        end else begin
          samp_ready = 1'b1;
          start      = 1'b0;
          k++;
        end
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk("sweep_done", 32'(done), 32'd1);
    chk("sample_count", 32'(k), 32'(exp_n));
    chk("n_samp", 32'(n_samp), 32'(exp_n));
    chk("in_final", 32'(in_w), 32'(exp_last));
    chk("busy_in_done", 32'(busy), 32'd0);
    chk("valid_in_done", 32'(samp_valid), 32'd0);
  endtask

  typedef struct {
    logic [15:0] s;
    logic [15:0] st;
    logic [15:0] sp;
    int          n;
    logic [15:0] last;
  } vec_t;

  vec_t tbl[7];

  initial begin
    tbl[0] = '{16'hFF00, 16'h0040, 16'h0100, 9, 16'h0100};  // -256..256 step 64
    tbl[1] = '{16'h7FF0, 16'h0010, 16'h7FFF, 1, 16'h7FF0};  // overflow stop
    tbl[2] = '{16'h0005, 16'h0000, 16'h0064, 1, 16'h0005};  // zero step
    tbl[3] = '{16'h0004, 16'hFFFE, 16'h0000, 3, 16'h0000};  // 4,2,0
    tbl[4] = '{16'h000A, 16'h0001, 16'h0005, 1, 16'h000A};  // start beyond stop
    tbl[5] = '{16'h8010, 16'hFFF0, 16'h8000, 2, 16'h8000};  // reaches -max then overflows
    tbl[6] = '{16'h0000, 16'h0003, 16'h000A, 4, 16'h0009};  // 0,3,6,9 stop not hit exactly

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; samp_ready = 1'b0;
    cfg_start = '0; cfg_step = '0; cfg_stop = '0;
    repeat (3) @(negedge clk);
    chk("rst_in", 32'(in_w), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_valid", 32'(samp_valid), 32'd0);
    chk("rst_samp_in", 32'(samp_in), 32'd0);
    chk("rst_samp_out", 32'(samp_out), 32'd0);
    chk("rst_idx", 32'(samp_idx), 32'd0);
    chk("rst_n_samp", 32'(n_samp), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run_sweep(tbl[i].s, tbl[i].st, tbl[i].sp, tbl[i].n, tbl[i].last, -1);
`ifdef SWEEP_STATS_EN
      if (i == 0) begin
        chk("out_min", 32'(out_min), 32'hFE00);
        chk("out_max", 32'(out_max), 32'h0200);
      end
`endif
    end

    // Backpressure at idx 3 plus start pulses while busy.
    run_sweep(16'hFF00, 16'h0040, 16'h0100, 9, 16'h0100, 3);

    // start and abort together in DONE: stays DONE.
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("start_abort_done", 32'(done), 32'd1);
    chk("start_abort_busy", 32'(busy), 32'd0);

    // Abort while sample idx 2 is waiting in EMIT.
    begin
      int  cyc = 0;
      cfg_start = 16'hFF00; cfg_step = 16'h0040; cfg_stop = 16'h0100;
      start = 1'b1; samp_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (!(samp_valid && samp_idx == 16'd2) && cyc < 200) begin
        @(negedge clk);
        cyc++;
      end
      chk("abort_reached_idx2", 32'(samp_valid && samp_idx == 16'd2), 32'd1);
      samp_ready = 1'b0; abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_valid", 32'(samp_valid), 32'd0);
      chk("abort_done", 32'(done), 32'd1);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_n_samp", 32'(n_samp), 32'd2);
      chk("abort_in_hold", 32'(in_w), 32'hFF80);
      repeat (3) @(negedge clk);
      chk("abort_in_still", 32'(in_w), 32'hFF80);
    end

    // Reset in the middle of SETTLE.
    samp_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_reset_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in", 32'(in_w), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_samp_in", 32'(samp_in), 32'd0);
    chk("mid_rst_samp_out", 32'(samp_out), 32'd0);
    chk("mid_rst_n_samp", 32'(n_samp), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (SET + 4) @(negedge clk);
    chk("post_rst_no_valid", 32'(samp_valid), 32'd0);
    chk("post_rst_idle", 32'(busy | done), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
